seq3: RTL and testbench
=======================

// Module: seq3
// PURPOSE
//  Parametrised microcode sequencer, successor to the 8-bit fixed sequencer.
//  Fetches one instruction per inst_en, drives the program address (next).
//  Emits a command word plus a one-hot write enable to NOREG output registers.
//  Adds call/return with a hardware stack, wait-on-input, jump-if-nonzero,
//  stack depth reporting and a sticky error flag.
// PARAMETERS
//  ADDR_W       8  program address width; next wraps modulo 2^ADDR_W
//  DATA_W       8  input-register and immediate width; ADDR_W <= DATA_W
//  CMD_W        4  command field width prepended to oreg data
//  NIREG        4  number of input registers; SRC_W = max(1,$clog2(NIREG))
//  NOREG        8  number of output registers; DST_W = max(1,$clog2(NOREG))
//  STACK_DEPTH  4  return-address stack entries (>=1)
// PORTS
//  clock     in   1                     rising-edge clock
//  reset     in   1                     synchronous, active-high
//  inst      in   INST_W                {code[3:0],tgt[ADDR_W],dst[DST_W],cmd[CMD_W],imm[DATA_W]}
//  inst_en   in   1                     inst valid this cycle
//  ireg      in   NIREG*DATA_W          input reg k at [k*DATA_W +: DATA_W]
//  next      out  ADDR_W                current program address (registered)
//  oreg      out  CMD_W+DATA_W          {cmd,data} (registered)
//  oreg_wen  out  NOREG                 one-hot write enable, 1-cycle pulse
//  sdepth    out  $clog2(STACK_DEPTH+1) stack entries in use
//  error     out  1                     sticky error, cleared only by reset
// BEHAVIOUR
//  Fields: src = imm[SRC_W-1:0]; R = ireg[src], src >= NIREG reads 0.
//  States: RESET -> READY (unconditional, 1 cycle); READY -> ERROR on fault; ERROR held until reset.
//  Reset (dominates all, any state): next=0, oreg=0, oreg_wen=0, sdepth=0, error=0, state=RESET.
//  RESET state ignores inst_en; all outputs stay 0.
//  READY, inst_en=0: next holds, oreg=0, oreg_wen=0.
//  READY, inst_en=1: instruction consumed this cycle; all effects visible next cycle.
//  oreg/oreg_wen are 0 for every opcode except CI/CR.
//  Opcodes (A = next+1, wraps):
//   0 NO: next=A
//   1 CI: next=A; oreg={cmd,imm}; oreg_wen=1<<dst
//   2 CR: next=A; oreg={cmd,R}; oreg_wen=1<<dst
//   3 JI: next=tgt
//   4 JR: next=R[ADDR_W-1:0]
//   5 JZ: next = (R==0) ? tgt : A
//   6 CL: push A; next=tgt; sdepth+1
//   7 RT: next=pop; sdepth-1
//   8 WT: next = (R!=0) ? A : next (stall while R==0)
//   9 JN: next = (R!=0) ? tgt : A
//  dst >= NOREG: oreg still loads, oreg_wen=0; no error.
//  Faults -> ERROR, error=1, next=0, stack untouched:
//   - undefined opcode
//   - CL with sdepth==STACK_DEPTH
//   - RT with sdepth==0
//  ERROR: next=0, oreg=0, oreg_wen=0, inst ignored.
//  CL at next=2^ADDR_W-1 pushes 0 (wrap).
// CONFIGURATION
//  SEQ3_STACK_EN defined: CL/RT implemented as above; stack storage present.
//  SEQ3_STACK_EN undefined: no stack storage; sdepth tied 0.
//   Opcodes 6/7 are undefined -> ERROR.
// TESTING (defaults; code[26:23] tgt[22:15] dst[14:12] cmd[11:8] imm[7:0])
//  reset 2 cycles, release -> next=0, oreg=0, oreg_wen=0, error=0.
//   READY after 1 idle cycle.
//  At next=0: CI dst=5 cmd=0xA imm=0x3C -> next cycle oreg=0xA3C, oreg_wen=0x20 for 1 cycle, next=1.
//  At next=0x10: CL tgt=0x40 -> next=0x40, sdepth=1.
//   Then RT -> next=0x11, sdepth=0.
//  4 CLs -> sdepth=4; 5th CL -> error=1, next=0, stays until reset.
//   Separately RT at sdepth=0 -> error=1.
//  JZ tgt=0x80 src=2: ireg2=0 -> next=0x80; ireg2=5 -> next=addr+1.
//   WT src=1 with ireg1=0 for 3 cycles -> next held; ireg1=1 -> next+1.
//  next=0xFF, NO -> next=0x00.
//   Opcode 0xF -> error=1.
//   Build without SEQ3_STACK_EN: CL -> error=1.

Source files
------------

// File: rtl/seq3.sv
// seq3: microcode sequencer with call/return stack, wait-on-input and conditional jumps.
// Define SEQ3_STACK_EN to build the return-address stack; otherwise CL/RT are undefined opcodes.
module seq3 #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int CMD_W       = 4,
    parameter int NIREG       = 4,
    parameter int NOREG       = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SRC_W  = NIREG > 1 ? $clog2(NIREG) : 1,
    localparam int DST_W  = NOREG > 1 ? $clog2(NOREG) : 1,
    localparam int SD_W   = $clog2(STACK_DEPTH + 1),
    localparam int INST_W = 4 + ADDR_W + DST_W + CMD_W + DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [INST_W-1:0]        inst,
    input  logic                     inst_en,
    input  logic [NIREG*DATA_W-1:0]  ireg,
    output logic [ADDR_W-1:0]        next,
    output logic [CMD_W+DATA_W-1:0]  oreg,
    output logic [NOREG-1:0]         oreg_wen,
    output logic [SD_W-1:0]          sdepth,
    output logic                     error
);
    typedef enum logic [1:0] {RESET, READY, ERROR} state_t;
    state_t state, state_n;
    logic [3:0] code;
    logic [ADDR_W-1:0] tgt, inc, next_n;
    logic [DST_W-1:0] dst;
    logic [CMD_W-1:0] cmd;
    logic [DATA_W-1:0] imm, r;
    logic [DATA_W-1:0] ir [2**SRC_W];
    logic [CMD_W+DATA_W-1:0] oreg_n;
    logic [NOREG-1:0] wen_n;
    logic fault;
`ifdef SEQ3_STACK_EN
    localparam int PTR_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];
    logic [SD_W-1:0] sd_n, sd_m1;
    logic push;
    assign sd_m1 = sdepth - 1'b1;
`endif
    assign {code, tgt, dst, cmd, imm} = inst;
    assign inc = next + 1'b1;
    // Unpopulated source selects read as zero.
    for (genvar k = 0; k < 2**SRC_W; k++) begin : g_ir
        if (k < NIREG) begin : g_v
            assign ir[k] = ireg[k*DATA_W +: DATA_W];
        end else begin : g_z
            assign ir[k] = '0;
        end
    end
    assign r = ir[imm[SRC_W-1:0]];
    assign error = state == ERROR;

    always_comb begin
        state_n = state;
        next_n = next;
        oreg_n = '0;
        wen_n = '0;
        fault = 1'b0;
`ifdef SEQ3_STACK_EN
        sd_n = sdepth;
        push = 1'b0;
`endif
        if (state == RESET) begin
            state_n = READY;
            next_n = '0;
        end else if (state == ERROR) begin
            next_n = '0;
        end else if (inst_en) begin
            case (code)
                4'd0: next_n = inc;
                4'd1: begin
                    next_n = inc;
                    oreg_n = {cmd, imm};
                    wen_n = NOREG'(1) << dst;
                end
                4'd2: begin
                    next_n = inc;
                    oreg_n = {cmd, r};
                    wen_n = NOREG'(1) << dst;
                end
                4'd3: next_n = tgt;
                4'd4: next_n = r[ADDR_W-1:0];
                4'd5: next_n = r == '0 ? tgt : inc;
`ifdef SEQ3_STACK_EN
                4'd6: begin
                    fault = sdepth == SD_W'(STACK_DEPTH);
                    push = !fault;
                    next_n = tgt;
                    sd_n = sdepth + 1'b1;
                end
                4'd7: begin
                    fault = sdepth == '0;
                    next_n = stk[PTR_W'(sd_m1)];
                    sd_n = sd_m1;
                end
`endif
                4'd8: next_n = r != '0 ? inc : next;
                4'd9: next_n = r != '0 ? tgt : inc;
                default: fault = 1'b1;
            endcase
            if (fault) begin
                state_n = ERROR;
                next_n = '0;
`ifdef SEQ3_STACK_EN
                sd_n = sdepth;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RESET;
            next <= '0;
            oreg <= '0;
            oreg_wen <= '0;
        end else begin
            state <= state_n;
            next <= next_n;
            oreg <= oreg_n;
            oreg_wen <= wen_n;
        end
    end

`ifdef SEQ3_STACK_EN
    always_ff @(posedge clock) begin
        sdepth <= reset ? '0 : sd_n;
        if (push && !reset) stk[PTR_W'(sdepth)] <= inc;
    end
`else
    assign sdepth = '0;
`endif
endmodule

// File: tb/tb_seq3.sv
// tb_seq3: scoreboard bench for seq3; a reference model queues expected outputs per driven cycle.
// Stack scenarios follow SEQ3_STACK_EN so either build of the design can be checked.
module tb_seq3;
    logic clock = 1'b0, reset = 1'b1, inst_en = 1'b0, error;
    logic [26:0] inst = '0;
    logic [31:0] ireg = '0;
    logic [7:0] next, oreg_wen;
    logic [11:0] oreg;
    logic [2:0] sdepth;
    typedef struct packed {
        logic [7:0] next;
        logic [11:0] oreg;
        logic [7:0] wen;
        logic [2:0] sd;
        logic err;
    } exp_t;
    exp_t sbq[$];
    int tests = 0, fails = 0;
    int m_state = 0;
    logic [7:0] m_next = '0;
    logic [7:0] m_stk[$];
`ifdef SEQ3_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    seq3 dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en), .ireg(ireg),
        .next(next), .oreg(oreg), .oreg_wen(oreg_wen), .sdepth(sdepth), .error(error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] mk(input logic [3:0] c, input logic [7:0] t, input logic [2:0] d,
                                       input logic [3:0] cm, input logic [7:0] im);
        return {c, t, d, cm, im};
    endfunction

    task automatic model(input logic en, input logic [26:0] i);
        exp_t e;
        logic [7:0] a, r;
        logic f;
        e = '0;
        f = 1'b0;
        a = m_next + 8'd1;
        r = ireg[32'(i[1:0]) * 8 +: 8];
        if (m_state == 0) m_state = 1;
        else if (m_state == 2) m_next = '0;
        else if (en) begin
            case (i[26:23])
                4'd0: m_next = a;
                4'd1: begin m_next = a; e.oreg = i[11:0]; e.wen = 8'd1 << i[14:12]; end
                4'd2: begin m_next = a; e.oreg = {i[11:8], r}; e.wen = 8'd1 << i[14:12]; end
                4'd3: m_next = i[22:15];
                4'd4: m_next = r;
                4'd5: m_next = (r == 8'd0) ? i[22:15] : a;
                4'd6: if (STK && m_stk.size() < 4) begin m_stk.push_back(a); m_next = i[22:15]; end else f = 1'b1;
                4'd7: if (STK && m_stk.size() > 0) m_next = m_stk.pop_back(); else f = 1'b1;
                4'd8: if (r != 8'd0) m_next = a;
                4'd9: m_next = (r != 8'd0) ? i[22:15] : a;
                default: f = 1'b1;
            endcase
            if (f) begin m_state = 2; m_next = '0; end
        end
        e.next = m_next;
        e.sd = 3'(m_stk.size());
        e.err = (m_state == 2);
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic en, input logic [26:0] i);
        exp_t e;
        inst_en = en;
        inst = i;
        model(en, i);
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check("next", 32'(next), 32'(e.next));
        check("oreg", 32'(oreg), 32'(e.oreg));
        check("oreg_wen", 32'(oreg_wen), 32'(e.wen));
        check("sdepth", 32'(sdepth), 32'(e.sd));
        check("error", 32'(error), 32'(e.err));
        inst_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_en = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            check("rst_next", 32'(next), 32'h0);
            check("rst_oreg", 32'(oreg), 32'h0);
            check("rst_wen", 32'(oreg_wen), 32'h0);
            check("rst_sdepth", 32'(sdepth), 32'h0);
            check("rst_error", 32'(error), 32'h0);
        end
        reset = 1'b0;
        m_state = 0;
        m_next = '0;
        m_stk.delete();
        sbq.delete();
    endtask

    initial begin
        do_reset();
        cyc(1'b1, mk(4'd1, 8'h00, 3'd5, 4'hA, 8'h3C));
        check("reset_state_ignores", 32'(oreg_wen), 32'h0);
        cyc(1'b1, mk(4'd1, 8'h00, 3'd5, 4'hA, 8'h3C));
        check("ci_oreg", 32'(oreg), 32'hA3C);
        check("ci_wen", 32'(oreg_wen), 32'h20);
        check("ci_next", 32'(next), 32'h01);
        cyc(1'b0, '0);
        check("wen_pulse", 32'(oreg_wen), 32'h0);
        ireg = {8'h00, 8'h00, 8'h77, 8'h00};
        cyc(1'b1, mk(4'd2, 8'h00, 3'd3, 4'h5, 8'h01));
        check("cr_oreg", 32'(oreg), 32'h577);
        cyc(1'b1, mk(4'd3, 8'h10, 3'd0, 4'h0, 8'h00));
        check("ji_next", 32'(next), 32'h10);
`ifdef SEQ3_STACK_EN
        cyc(1'b1, mk(4'd6, 8'h40, 3'd0, 4'h0, 8'h00));
        check("cl_next", 32'(next), 32'h40);
        check("cl_sdepth", 32'(sdepth), 32'd1);
        cyc(1'b1, mk(4'd7, 8'h00, 3'd0, 4'h0, 8'h00));
        check("rt_next", 32'(next), 32'h11);
        check("rt_sdepth", 32'(sdepth), 32'd0);
`endif
        ireg = {8'hFF, 8'h00, 8'h00, 8'h00};
        cyc(1'b1, mk(4'd5, 8'h80, 3'd0, 4'h0, 8'h02));
        check("jz_taken", 32'(next), 32'h80);
        ireg = {8'hFF, 8'h05, 8'h00, 8'h00};
        cyc(1'b1, mk(4'd5, 8'h90, 3'd0, 4'h0, 8'h02));
        check("jz_fall", 32'(next), 32'h81);
        cyc(1'b1, mk(4'd9, 8'h20, 3'd0, 4'h0, 8'h02));
        check("jn_taken", 32'(next), 32'h20);
        ireg = {8'hFF, 8'h00, 8'h00, 8'h00};
        cyc(1'b1, mk(4'd9, 8'h60, 3'd0, 4'h0, 8'h02));
        check("jn_fall", 32'(next), 32'h21);
        repeat (3) cyc(1'b1, mk(4'd8, 8'h00, 3'd0, 4'h0, 8'h01));
        check("wt_hold", 32'(next), 32'h21);
        ireg = {8'hFF, 8'h00, 8'h01, 8'h00};
        cyc(1'b1, mk(4'd8, 8'h00, 3'd0, 4'h0, 8'h01));
        check("wt_go", 32'(next), 32'h22);
        cyc(1'b1, mk(4'd4, 8'h00, 3'd0, 4'h0, 8'h03));
        check("jr_next", 32'(next), 32'hFF);
        cyc(1'b1, mk(4'd0, 8'h00, 3'd0, 4'h0, 8'h00));
        check("wrap_next", 32'(next), 32'h00);
`ifdef SEQ3_STACK_EN
        cyc(1'b1, mk(4'd4, 8'h00, 3'd0, 4'h0, 8'h03));
        cyc(1'b1, mk(4'd6, 8'h05, 3'd0, 4'h0, 8'h00));
        cyc(1'b1, mk(4'd7, 8'h00, 3'd0, 4'h0, 8'h00));
        check("cl_wrap_ret", 32'(next), 32'h00);
        for (int k = 0; k < 4; k++) cyc(1'b1, mk(4'd6, 8'(8'h30 + k), 3'd0, 4'h0, 8'h00));
        check("stack_full", 32'(sdepth), 32'd4);
        cyc(1'b1, mk(4'd6, 8'h50, 3'd0, 4'h0, 8'h00));
        check("overflow_err", 32'(error), 32'd1);
        check("overflow_next", 32'(next), 32'h0);
        check("overflow_sd", 32'(sdepth), 32'd4);
`else
        cyc(1'b1, mk(4'd6, 8'h50, 3'd0, 4'h0, 8'h00));
        check("cl_undef_err", 32'(error), 32'd1);
`endif
        repeat (3) cyc(1'b1, mk(4'd1, 8'h00, 3'd1, 4'h3, 8'h44));
        check("err_sticky", 32'(error), 32'd1);
        check("err_oreg", 32'(oreg), 32'h0);
        do_reset();
        cyc(1'b0, '0);
        cyc(1'b1, mk(4'd7, 8'h00, 3'd0, 4'h0, 8'h00));
        check("underflow_err", 32'(error), 32'd1);
        do_reset();
        cyc(1'b0, '0);
        cyc(1'b1, mk(4'd3, 8'h33, 3'd0, 4'h0, 8'h00));
        cyc(1'b1, mk(4'hF, 8'h00, 3'd0, 4'h0, 8'h00));
        check("undef_err", 32'(error), 32'd1);
        check("undef_next", 32'(next), 32'h0);
        cyc(1'b1, mk(4'd3, 8'h44, 3'd0, 4'h0, 8'h00));
        do_reset();
        cyc(1'b0, '0);
        cyc(1'b1, mk(4'hA, 8'h00, 3'd0, 4'h0, 8'h00));
        check("op10_err", 32'(error), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
